// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline hazard sequencer and the stage registers.
// master drives the stage/hazard status; slave (the sequencer) returns stall/flush controls.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] src1;
   logic [REG_AW-1:0] src2;
   logic              two_src;
   logic              src1_valid;
   logic [REG_AW-1:0] EX_Dest;
   logic              EX_WB_EN;
   logic              EX_MEM_R_EN;
   logic [REG_AW-1:0] MEM_Dest;
   logic              MEM_WB_EN;
   logic              Branch_Taken;
   logic              mem_req;
   logic              mem_ready;
   logic              Freeze;
   logic              Flush;
   logic              ID_Flush;
   logic              pipe_stall;
   logic              mem_timeout;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output src1, src2, two_src, src1_valid, EX_Dest, EX_WB_EN, EX_MEM_R_EN,
             MEM_Dest, MEM_WB_EN, Branch_Taken, mem_req, mem_ready,
      input  Freeze, Flush, ID_Flush, pipe_stall, mem_timeout, stall_cnt
   );

   modport slave (
      input  src1, src2, two_src, src1_valid, EX_Dest, EX_WB_EN, EX_MEM_R_EN,
             MEM_Dest, MEM_WB_EN, Branch_Taken, mem_req, mem_ready,
      output Freeze, Flush, ID_Flush, pipe_stall, mem_timeout, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: memory-wait FSM, RAW hazard detect, branch flush, stall counter.
// Controls are combinational (0 latency); HAZARD_FORWARDING_EN reduces hazards to load-use.
module pipeline_hazard_ctrl #(
   parameter int REG_AW      = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hif
);
   typedef enum logic [1:0] {IDLE, MEM_WAIT, ERR} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           state;
   logic [7:0]       wait_cnt;
   logic             timeout_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             hazard;
   logic             stall;
   logic             freeze;
   logic             flush;
   logic             id_flush;
   logic             hz_stall;

`ifdef HAZARD_FORWARDING_EN
   logic unused_mem_fwd;
   assign unused_mem_fwd = ^{hif.MEM_Dest, hif.MEM_WB_EN};

   // MEM-stage producers are covered by forwarding; only a load in EX must stall.
   always_comb begin
      hazard = hif.EX_MEM_R_EN && hif.EX_WB_EN &&
               ((hif.src1_valid && (hif.src1 == hif.EX_Dest)) ||
                (hif.two_src    && (hif.src2 == hif.EX_Dest)));
   end
`else
   logic unused_ld;
   assign unused_ld = hif.EX_MEM_R_EN;

   always_comb begin
      hazard = (hif.src1_valid && hif.EX_WB_EN  && (hif.src1 == hif.EX_Dest))  ||
               (hif.two_src    && hif.EX_WB_EN  && (hif.src2 == hif.EX_Dest))  ||
               (hif.src1_valid && hif.MEM_WB_EN && (hif.src1 == hif.MEM_Dest)) ||
               (hif.two_src    && hif.MEM_WB_EN && (hif.src2 == hif.MEM_Dest));
   end
`endif

   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:     stall = hif.mem_req && !hif.mem_ready;
         MEM_WAIT: stall = !hif.mem_ready;
         default:  stall = 1'b0;
      endcase
   end

   // Stall outranks branch: EX is held and re-presents Branch_Taken once released.
   always_comb begin
      freeze   = 1'b0;
      flush    = 1'b0;
      id_flush = 1'b0;
      hz_stall = 1'b0;
      if (!reset) begin
         freeze = 1'b0;
      end else if (stall) begin
         freeze = 1'b1;
      end else if (hif.Branch_Taken) begin
         flush    = 1'b1;
         id_flush = 1'b1;
      end else if (hazard) begin
         freeze   = 1'b1;
         id_flush = 1'b1;
         hz_stall = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         wait_cnt    <= 8'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= 8'd0;
               if (hif.mem_req && !hif.mem_ready) state <= MEM_WAIT;
            end
            MEM_WAIT: begin
               if (hif.mem_ready) begin
                  state    <= IDLE;
                  wait_cnt <= 8'd0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state     <= ERR;
                  wait_cnt  <= 8'd0;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= ERR;
         endcase
         if (hz_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign hif.Freeze      = freeze;
   assign hif.Flush       = flush;
   assign hif.ID_Flush    = id_flush;
   assign hif.pipe_stall  = stall && reset;
   assign hif.mem_timeout = timeout_q;
   assign hif.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for hazard/branch priority,
// hand sequences for memory wait, timeout, mid-stall reset and counter saturation.
module tb_pipeline_hazard_ctrl;
   localparam int REG_AW = 4;
   localparam int CNT_W  = 16;
   localparam int TMO    = 8;
`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

   pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hif   (hif)
   );

   typedef struct {
      logic [3:0] src1, src2;
      logic       two_src, src1_valid;
      logic [3:0] ex_dest;
      logic       ex_wb, ex_ld;
      logic [3:0] mem_dest;
      logic       mem_wb, br;
      logic       e_freeze, e_flush, e_idflush, e_inc;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(logic [3:0] s1, logic [3:0] s2, logic ts, logic s1v,
                               logic [3:0] exd, logic exw, logic exl,
                               logic [3:0] md, logic mw, logic br,
                               logic ef, logic efl, logic eid, logic einc);
      vec_t v;
      v.src1 = s1; v.src2 = s2; v.two_src = ts; v.src1_valid = s1v;
      v.ex_dest = exd; v.ex_wb = exw; v.ex_ld = exl;
      v.mem_dest = md; v.mem_wb = mw; v.br = br;
      v.e_freeze = ef; v.e_flush = efl; v.e_idflush = eid; v.e_inc = einc;
      return v;
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      hif.src1 = 0; hif.src2 = 0; hif.two_src = 0; hif.src1_valid = 0;
      hif.EX_Dest = 0; hif.EX_WB_EN = 0; hif.EX_MEM_R_EN = 0;
      hif.MEM_Dest = 0; hif.MEM_WB_EN = 0; hif.Branch_Taken = 0;
      hif.mem_req = 0; hif.mem_ready = 0;
   endtask

   // Load-use hazard: stalls in both hazard-equation variants.
   task automatic load_use_hazard(input logic on);
      hif.src1 = 4'd3; hif.src1_valid = on; hif.EX_Dest = 4'd3;
      hif.EX_WB_EN = on; hif.EX_MEM_R_EN = on;
   endtask

   task automatic apply(input vec_t v);
      hif.src1 = v.src1; hif.src2 = v.src2; hif.two_src = v.two_src;
      hif.src1_valid = v.src1_valid; hif.EX_Dest = v.ex_dest;
      hif.EX_WB_EN = v.ex_wb; hif.EX_MEM_R_EN = v.ex_ld;
      hif.MEM_Dest = v.mem_dest; hif.MEM_WB_EN = v.mem_wb; hif.Branch_Taken = v.br;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      longint exp_cnt;
      int     n;
      bit     early;

      //           s1 s2 ts s1v exd exw exl md mw br   F          Fl IDF        inc
      vecs[0]  = mk(3, 0, 0, 1,  3,  1,  0, 0, 0, 0,  !FWD,      0, !FWD,      !FWD);
      vecs[1]  = mk(3, 0, 0, 1,  3,  1,  0, 0, 0, 1,  0,         1, 1,         0);
      vecs[2]  = mk(3, 0, 0, 0,  3,  1,  1, 0, 0, 0,  0,         0, 0,         0);
      vecs[3]  = mk(0, 7, 1, 0,  7,  1,  1, 0, 0, 0,  1,         0, 1,         1);
      vecs[4]  = mk(0, 7, 0, 0,  7,  1,  1, 0, 0, 0,  0,         0, 0,         0);
      vecs[5]  = mk(5, 0, 0, 1,  0,  0,  0, 5, 1, 0,  !FWD,      0, !FWD,      !FWD);
      vecs[6]  = mk(5, 0, 0, 1,  0,  0,  0, 5, 0, 0,  0,         0, 0,         0);
      vecs[7]  = mk(2, 0, 0, 1,  2,  0,  1, 0, 0, 0,  0,         0, 0,         0);
      vecs[8]  = mk(9, 0, 0, 1,  9,  1,  1, 0, 0, 0,  1,         0, 1,         1);
      vecs[9]  = mk(1, 2, 1, 1,  4,  1,  1, 6, 1, 1,  0,         1, 1,         0);
      vecs[10] = mk(15,15,1, 1,  14, 1,  1, 13,1, 0,  0,         0, 0,         0);
      vecs[11] = mk(0, 13,1, 0,  0,  0,  0, 13,1, 0,  !FWD,      0, !FWD,      !FWD);

      // Reset state, with a hazard and a stalled access presented during reset.
      idle_inputs();
      reset = 1'b0;
      load_use_hazard(1'b1);
      hif.mem_req = 1'b1;
      #12;
      chk("rst_freeze",   hif.Freeze,      0);
      chk("rst_idflush",  hif.ID_Flush,    0);
      chk("rst_stall",    hif.pipe_stall,  0);
      chk("rst_timeout",  hif.mem_timeout, 0);
      chk("rst_cnt",      hif.stall_cnt,   0);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      next_cycle();

      exp_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         apply(vecs[i]);
         #4;
         chk($sformatf("v%0d_freeze", i),   hif.Freeze,     vecs[i].e_freeze);
         chk($sformatf("v%0d_flush", i),    hif.Flush,      vecs[i].e_flush);
         chk($sformatf("v%0d_idflush", i),  hif.ID_Flush,   vecs[i].e_idflush);
         chk($sformatf("v%0d_pstall", i),   hif.pipe_stall, 0);
         exp_cnt += vecs[i].e_inc;
         next_cycle();
         chk($sformatf("v%0d_cnt", i),      hif.stall_cnt,  exp_cnt);
      end
      idle_inputs();

      // Three wait cycles; hazard in the first and a branch in the second are masked.
      hif.mem_req = 1'b1;
      load_use_hazard(1'b1);
      #4;
      chk("mw1_stall",   hif.pipe_stall, 1);
      chk("mw1_freeze",  hif.Freeze,     1);
      chk("mw1_idflush", hif.ID_Flush,   0);
      next_cycle();
      chk("mw1_cnt",     hif.stall_cnt,  exp_cnt);
      load_use_hazard(1'b0);
      hif.Branch_Taken = 1'b1;
      #4;
      chk("mw2_stall",   hif.pipe_stall, 1);
      chk("mw2_freeze",  hif.Freeze,     1);
      chk("mw2_flush",   hif.Flush,      0);
      next_cycle();
      hif.Branch_Taken = 1'b0;
      #4;
      chk("mw3_stall",   hif.pipe_stall, 1);
      next_cycle();
      hif.mem_ready = 1'b1;
      #4;
      chk("mw4_stall",   hif.pipe_stall, 0);
      chk("mw4_freeze",  hif.Freeze,     0);
      next_cycle();
      hif.mem_req = 1'b0;
      hif.mem_ready = 1'b0;
      #4;
      chk("mw5_stall",   hif.pipe_stall, 0);

      // Single-cycle access must not enter the wait state.
      next_cycle();
      hif.mem_req = 1'b1;
      hif.mem_ready = 1'b1;
      #4;
      chk("sc_stall",    hif.pipe_stall, 0);
      next_cycle();
      hif.mem_req = 1'b0;
      hif.mem_ready = 1'b0;
      #4;
      chk("sc_after",    hif.pipe_stall, 0);

      // Reset while waiting with the wait counter at 5.
      next_cycle();
      hif.mem_req = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #4;
         chk($sformatf("rw%0d_stall", c), hif.pipe_stall, 1);
         next_cycle();
      end
      hif.Branch_Taken = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      chk("rw_rst_stall",  hif.pipe_stall, 0);
      chk("rw_rst_freeze", hif.Freeze,     0);
      chk("rw_rst_flush",  hif.Flush,      0);
      chk("rw_rst_cnt",    hif.stall_cnt,  0);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      next_cycle();
      #4;
      chk("rw_idle_stall", hif.pipe_stall, 0);
      chk("rw_idle_cnt",   hif.stall_cnt,  0);

      // Timeout: 1 entry cycle plus TMO wait cycles, then ERR with stall released.
      next_cycle();
      hif.mem_req = 1'b1;
      n = 0;
      early = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #4;
         if (!hif.pipe_stall) break;
         if (hif.mem_timeout) early = 1'b1;
         n++;
         next_cycle();
      end
      chk("to_cycles",   n, TMO + 1);
      chk("to_early",    early, 0);
      chk("to_flag",     hif.mem_timeout, 1);
      chk("to_stall",    hif.pipe_stall,  0);
      load_use_hazard(1'b1);
      #1;
      chk("err_freeze",  hif.Freeze,   1);
      chk("err_idflush", hif.ID_Flush, 1);
      next_cycle();
      idle_inputs();
      repeat (3) next_cycle();
      #4;
      chk("err_sticky",  hif.mem_timeout, 1);
      chk("err_stall",   hif.pipe_stall,  0);
      reset = 1'b0;
      #1;
      chk("err_rst_to",  hif.mem_timeout, 0);
      @(negedge clk);
      reset = 1'b1;
      next_cycle();

      // Saturation of the hazard stall counter.
      load_use_hazard(1'b1);
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_65534", hif.stall_cnt, 65534);
      @(posedge clk);
      #1;
      chk("sat_max",   hif.stall_cnt, 65535);
      repeat (4500) @(posedge clk);
      #1;
      chk("sat_hold",  hif.stall_cnt, 65535);
      chk("sat_freeze", hif.Freeze, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
